// File: rtl/ysyx_23060025_trap_ctrl_pkg.sv
// Shared constants for the trap controller: CSR addresses, op encodings,
// mstatus bit positions, FSM states and request decode helpers.
package ysyx_23060025_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0] OP_CSRRW = 3'b000;
    localparam logic [2:0] OP_CSRRS = 3'b001;
    localparam logic [2:0] OP_CSRRC = 3'b010;
    localparam logic [2:0] OP_ECALL = 3'b100;
    localparam logic [2:0] OP_MRET  = 3'b101;

    localparam int ILL_CAUSE = 2;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LO   = 11;
    localparam int MPP_HI   = 12;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CSR_RW,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STATUS,
        S_T_VEC,
        S_M_EPC,
        S_M_STATUS,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        FN_RW,
        FN_RS,
        FN_RC
    } csr_fn_e;

    typedef enum logic [1:0] {
        K_CSR,
        K_TRAP,
        K_MRET,
        K_ILL
    } kind_e;

    function automatic kind_e op_kind(input logic [2:0] op);
        unique case (op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: return K_CSR;
            OP_ECALL: return K_TRAP;
            OP_MRET:  return K_MRET;
            default:  return K_ILL;
        endcase
    endfunction

    function automatic csr_fn_e op_fn(input logic [2:0] op);
        unique case (op)
            OP_CSRRS: return FN_RS;
            OP_CSRRC: return FN_RC;
            default:  return FN_RW;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060025_trap_ctrl_if.sv
// EXU <-> trap controller request/response handshake bundle.
interface ysyx_23060025_trap_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_op;
    logic [11:0]           req_csr_addr;
    logic [DATA_WIDTH-1:0] req_src;
    logic [DATA_WIDTH-1:0] req_pc;
    logic [DATA_WIDTH-1:0] req_cause;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_redirect;
    logic [DATA_WIDTH-1:0] resp_npc;

    modport master (
        output req_valid, req_op, req_csr_addr,
        output req_src, req_pc, req_cause, resp_ready,
        input  req_ready, resp_valid, resp_rdata,
        input  resp_redirect, resp_npc
    );

    modport slave (
        input  req_valid, req_op, req_csr_addr,
        input  req_src, req_pc, req_cause, resp_ready,
        output req_ready, resp_valid, resp_rdata,
        output resp_redirect, resp_npc
    );
endinterface

// File: rtl/ysyx_23060025_trap_ctrl_csr_alu.sv
// Combinational CSR read-modify-write and mstatus trap/return transforms.
module ysyx_23060025_csr_alu
    import ysyx_23060025_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  csr_fn_e               fn,
    input  logic [DATA_WIDTH-1:0] old,
    input  logic [DATA_WIDTH-1:0] src,
    output logic [DATA_WIDTH-1:0] csr_res,
    output logic [DATA_WIDTH-1:0] trap_st,
    output logic [DATA_WIDTH-1:0] mret_st
);
    always_comb begin
        unique case (fn)
            FN_RS:   csr_res = old | src;
            FN_RC:   csr_res = old & ~src;
            default: csr_res = src;
        endcase

        trap_st                 = old;
        trap_st[MPIE_BIT]       = old[MIE_BIT];
        trap_st[MIE_BIT]        = 1'b0;
        trap_st[MPP_HI:MPP_LO]  = 2'b11;

        mret_st                 = old;
        mret_st[MIE_BIT]        = old[MPIE_BIT];
        mret_st[MPIE_BIT]       = 1'b1;
        mret_st[MPP_HI:MPP_LO]  = 2'b11;
    end
endmodule

// File: rtl/ysyx_23060025_trap_ctrl.sv
// CSR access / ECALL / MRET sequencer, one CSR write per cycle.
// Define YSYX_23060025_TRAP_MSTATUS_EN to enable the mstatus save/restore steps.
module ysyx_23060025_trap_ctrl
    import ysyx_23060025_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    ysyx_23060025_trap_ctrl_if.slave bus,
    output logic [11:0]           csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_we,
    output logic [11:0]           csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata
);
`ifdef YSYX_23060025_TRAP_MSTATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    csr_fn_e               fn_q;
    logic [11:0]           addr_q;
    logic [DATA_WIDTH-1:0] src_q, pc_q, cause_q;
    logic [DATA_WIDTH-1:0] rdata_q, npc_q;
    logic                  redir_q;
    logic                  fire;
    kind_e                 req_kind;
    logic [DATA_WIDTH-1:0] alu_res, trap_st, mret_st;

    assign bus.req_ready     = reset & (state_q == S_IDLE);
    assign fire              = bus.req_valid & bus.req_ready;
    assign req_kind          = op_kind(bus.req_op);
    assign bus.resp_valid    = state_q == S_RESP;
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_npc      = npc_q;
    assign bus.resp_redirect = redir_q;

    ysyx_23060025_csr_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .fn      (fn_q),
        .old     (csr_rdata),
        .src     (src_q),
        .csr_res (alu_res),
        .trap_st (trap_st),
        .mret_st (mret_st)
    );

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    unique case (req_kind)
                        K_CSR:   state_d = S_CSR_RW;
                        K_MRET:  state_d = S_M_EPC;
                        default: state_d = S_T_EPC;
                    endcase
                end
            end
            S_CSR_RW:   state_d = S_RESP;
            S_T_EPC:    state_d = S_T_CAUSE;
            S_T_CAUSE:  state_d = STATUS_EN ? S_T_STATUS : S_T_VEC;
            S_T_STATUS: state_d = S_T_VEC;
            S_T_VEC:    state_d = S_RESP;
            S_M_EPC:    state_d = STATUS_EN ? S_M_STATUS : S_RESP;
            S_M_STATUS: state_d = S_RESP;
            S_RESP:     if (bus.resp_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        csr_raddr = 12'h0;
        csr_we    = 1'b0;
        csr_waddr = 12'h0;
        csr_wdata = '0;
        unique case (state_q)
            S_CSR_RW: begin
                csr_raddr = addr_q;
                csr_waddr = addr_q;
                csr_wdata = alu_res;
                // set/clear with x0 source must not touch the CSR
                csr_we    = (fn_q == FN_RW) | (src_q != '0);
            end
            S_T_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = pc_q;
            end
            S_T_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause_q;
            end
            S_T_STATUS: begin
                csr_raddr = CSR_MSTATUS;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = trap_st;
                csr_we    = STATUS_EN;
            end
            S_T_VEC: csr_raddr = CSR_MTVEC;
            S_M_EPC: csr_raddr = CSR_MEPC;
            S_M_STATUS: begin
                csr_raddr = CSR_MSTATUS;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = mret_st;
                csr_we    = STATUS_EN;
            end
            default: csr_we = 1'b0;
        endcase
        if (!reset) csr_we = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fn_q    <= FN_RW;
            addr_q  <= 12'h0;
            src_q   <= '0;
            pc_q    <= '0;
            cause_q <= '0;
            rdata_q <= '0;
            npc_q   <= '0;
            redir_q <= 1'b0;
        end else begin
            if (fire) begin
                fn_q    <= op_fn(bus.req_op);
                addr_q  <= bus.req_csr_addr;
                src_q   <= bus.req_src;
                pc_q    <= bus.req_pc;
                cause_q <= (req_kind == K_ILL) ? DATA_WIDTH'(ILL_CAUSE)
                                               : bus.req_cause;
                rdata_q <= '0;
                npc_q   <= '0;
                redir_q <= req_kind != K_CSR;
            end
            if (state_q == S_CSR_RW) rdata_q <= csr_rdata;
            if (state_q == S_T_VEC || state_q == S_M_EPC) npc_q <= csr_rdata;
        end
    end
endmodule

// File: tb/tb_ysyx_23060025_trap_ctrl.sv
// Self-checking bench: CSR file model, write-sequence scoreboard, directed ops.
module tb_ysyx_23060025_trap_ctrl;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_23060025_trap_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    logic [11:0]   csr_raddr, csr_waddr;
    logic [DW-1:0] csr_rdata, csr_wdata;
    logic          csr_we;

    ysyx_23060025_trap_ctrl #(.DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .csr_raddr (csr_raddr),
        .csr_rdata (csr_rdata),
        .csr_we    (csr_we),
        .csr_waddr (csr_waddr),
        .csr_wdata (csr_wdata)
    );

    logic [31:0] csr_file [0:4095];
    logic [31:0] mdl      [0:4095];
    logic        pre_en = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [31:0] pre_data = 32'h0;

    assign csr_rdata = csr_file[csr_raddr];
    always @(posedge clock) begin
        if (csr_we) csr_file[csr_waddr] <= csr_wdata;
        if (pre_en) csr_file[pre_addr] <= pre_data;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        int          off;
    } wr_t;
    wr_t wq[$];
    wr_t e_cmp;

    logic        exp_redir = 1'b0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] exp_npc = 32'h0;
    bit          chk_rdata = 1'b0;
    int          exp_lat = 0;
    int          hs_cyc = 0;
    bit          resp_seen = 1'b0;
    bit          mon_en = 1'b0;
    logic [31:0] got_rdata, got_npc;
    logic        got_redir;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] trap_f(input logic [31:0] m);
        logic [31:0] mie;
        mie = (m >> 3) & 32'h1;
        return (m & ~32'h1888) | (mie << 7) | 32'h1800;
    endfunction

    function automatic logic [31:0] mret_f(input logic [31:0] m);
        logic [31:0] mpie;
        mpie = (m >> 7) & 32'h1;
        return (m & ~32'h1888) | (mpie << 3) | 32'h80 | 32'h1800;
    endfunction

    always @(negedge clock) begin
        if (mon_en && reset) begin
            if (csr_we) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write: got addr 0x%0h data 0x%0h expected no write",
                             csr_waddr, csr_wdata);
                end else begin
                    e_cmp = wq.pop_front();
                    check("write_addr", 32'(csr_waddr), 32'(e_cmp.a));
                    check("write_data", csr_wdata, e_cmp.d);
                    check("write_cycle", cyc - hs_cyc, e_cmp.off);
                end
            end
            if (bus.resp_valid) begin
                if (!resp_seen) begin
                    resp_seen = 1'b1;
                    check("latency", cyc - hs_cyc, exp_lat);
                    check("writes_done", wq.size(), 0);
                end
                check("resp_redirect", 32'(bus.resp_redirect), 32'(exp_redir));
                if (chk_rdata) check("resp_rdata", bus.resp_rdata, exp_rdata);
                if (exp_redir) check("resp_npc", bus.resp_npc, exp_npc);
                check("we_in_resp", 32'(csr_we), 0);
            end
            if (bus.req_ready) check("we_in_idle", 32'(csr_we), 0);
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        @(negedge clock);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        mdl[a] = d;
        @(posedge clock);
        #1 pre_en = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] src, input logic [31:0] pc,
                         input logic [31:0] cause, input int hold);
        bit ok;
        resp_seen = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_csr_addr = addr;
        bus.req_src = src;
        bus.req_pc = pc;
        bus.req_cause = cause;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                hs_cyc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("req_accept", 32'(ok), 1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("resp_arrive", 32'(ok), 1);
        got_rdata = bus.resp_rdata;
        got_npc = bus.resp_npc;
        got_redir = bus.resp_redirect;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", 32'(bus.resp_valid), 1);
            check("hold_npc", bus.resp_npc, got_npc);
        end
        check("no_ready_in_resp", 32'(bus.req_ready), 0);
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1 bus.resp_ready = 1'b0;
        @(negedge clock);
        check("ready_after_resp", 32'(bus.req_ready), 1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] src, input logic [31:0] pc,
                         input logic [31:0] cause, input int hold);
        logic [31:0] old, nw, cz;
        wq.delete();
        if (op == 3'b000 || op == 3'b001 || op == 3'b010) begin
            old = mdl[addr];
            if (op == 3'b000) nw = src;
            else if (op == 3'b001) nw = old | src;
            else nw = old & ~src;
            if (op == 3'b000 || src != 0) begin
                wq.push_back('{addr, nw, 1});
                mdl[addr] = nw;
            end
            exp_rdata = old;
            chk_rdata = 1'b1;
            exp_redir = 1'b0;
            exp_lat = 2;
        end else if (op == 3'b101) begin
            exp_npc = mdl[12'h341];
            exp_redir = 1'b1;
            chk_rdata = 1'b0;
            exp_lat = 2;
`ifdef YSYX_23060025_TRAP_MSTATUS_EN
            nw = mret_f(mdl[12'h300]);
            wq.push_back('{12'h300, nw, 2});
            mdl[12'h300] = nw;
            exp_lat = 3;
`endif
        end else begin
            cz = (op == 3'b100) ? cause : 32'd2;
            wq.push_back('{12'h341, pc, 1});
            wq.push_back('{12'h342, cz, 2});
            mdl[12'h341] = pc;
            mdl[12'h342] = cz;
            exp_lat = 4;
`ifdef YSYX_23060025_TRAP_MSTATUS_EN
            nw = trap_f(mdl[12'h300]);
            wq.push_back('{12'h300, nw, 3});
            mdl[12'h300] = nw;
            exp_lat = 5;
`endif
            exp_npc = mdl[12'h305];
            exp_redir = 1'b1;
            chk_rdata = 1'b0;
        end
        drive(op, addr, src, pc, cause, hold);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            csr_file[i] = 32'h0;
            mdl[i] = 32'h0;
        end
        bus.req_valid = 1'b0;
        bus.req_op = 3'b000;
        bus.req_csr_addr = 12'h0;
        bus.req_src = 32'h0;
        bus.req_pc = 32'h0;
        bus.req_cause = 32'h0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_redirect", 32'(bus.resp_redirect), 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_npc", bus.resp_npc, 0);
        check("rst_we", 32'(csr_we), 0);
        reset = 1'b1;
        @(negedge clock);
        check("ready_after_rst", 32'(bus.req_ready), 1);
        mon_en = 1'b1;

        issue(3'b000, 12'h305, 32'h8000_0100, 32'h0, 32'h0, 0);
        check("rw_mtvec_lit", csr_file[12'h305], 32'h8000_0100);
        check("rw_rdata_lit", got_rdata, 32'h0);
        check("rw_redir_lit", 32'(got_redir), 0);

        preload(12'h300, 32'h0000_1800);
        issue(3'b001, 12'h300, 32'h0, 32'h0, 32'h0, 0);
        check("rs0_rdata_lit", got_rdata, 32'h1800);
        check("rs0_mstatus_lit", csr_file[12'h300], 32'h1800);

        issue(3'b001, 12'h300, 32'h8, 32'h0, 32'h0, 1);
        check("rs_mstatus_lit", csr_file[12'h300], 32'h1808);
        issue(3'b010, 12'h300, 32'h1000, 32'h0, 32'h0, 0);
        check("rc_mstatus_lit", csr_file[12'h300], 32'h0808);
        check("rc_rdata_lit", got_rdata, 32'h1808);

        preload(12'h300, 32'h8);
        issue(3'b100, 12'h0, 32'h0, 32'h8000_0040, 32'd11, 0);
        check("ecall_mepc_lit", csr_file[12'h341], 32'h8000_0040);
        check("ecall_mcause_lit", csr_file[12'h342], 32'd11);
        check("ecall_npc_lit", got_npc, 32'h8000_0100);
        check("ecall_redir_lit", 32'(got_redir), 1);
`ifdef YSYX_23060025_TRAP_MSTATUS_EN
        check("ecall_mstatus_lit", csr_file[12'h300], 32'h1880);
`else
        check("ecall_mstatus_lit", csr_file[12'h300], 32'h8);
`endif

        preload(12'h341, 32'h8000_0044);
        issue(3'b101, 12'h0, 32'h0, 32'h0, 32'h0, 3);
        check("mret_npc_lit", got_npc, 32'h8000_0044);
        check("mret_redir_lit", 32'(got_redir), 1);

        issue(3'b111, 12'h0, 32'h0, 32'h8000_0010, 32'h55, 0);
        check("ill_mcause_lit", csr_file[12'h342], 32'd2);
        check("ill_mepc_lit", csr_file[12'h341], 32'h8000_0010);
        check("ill_npc_lit", got_npc, 32'h8000_0100);

        issue(3'b000, 12'h340, 32'hDEAD_BEEF, 32'h0, 32'h0, 2);
        check("rw_mscratch_lit", csr_file[12'h340], 32'hDEAD_BEEF);

        wq.delete();
        wq.push_back('{12'h341, 32'h8000_0080, 1});
        mdl[12'h341] = 32'h8000_0080;
        exp_lat = 99;
        resp_seen = 1'b0;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op = 3'b100;
        bus.req_pc = 32'h8000_0080;
        bus.req_cause = 32'd11;
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus.req_ready) begin
                    hs_cyc = cyc;
                    ok = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            check("rst_seq_accept", 32'(ok), 1);
        end
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("midrst_we", 32'(csr_we), 0);
        check("midrst_ready", 32'(bus.req_ready), 0);
        @(posedge clock);
        @(negedge clock);
        check("midrst_valid", 32'(bus.resp_valid), 0);
        check("midrst_redirect", 32'(bus.resp_redirect), 0);
        check("midrst_rdata", bus.resp_rdata, 0);
        check("midrst_npc", bus.resp_npc, 0);
        check("midrst_mcause", csr_file[12'h342], 32'd2);
        check("midrst_mepc", csr_file[12'h341], 32'h8000_0080);
        check("midrst_queue", wq.size(), 0);
        reset = 1'b1;
        @(negedge clock);
        check("postrst_ready", 32'(bus.req_ready), 1);
        check("postrst_valid", 32'(bus.resp_valid), 0);

        issue(3'b001, 12'h342, 32'h4, 32'h0, 32'h0, 0);
        check("post_rs_mcause_lit", csr_file[12'h342], 32'h6);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
